alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/alu_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// alu_decoder: single-entry registered RV32I ALU decode stage with a
// valid/ready handshake on both sides. Each accepted instruction word is
// decoded combinationally and captured into the output register, giving a
// latency of one cycle and one instruction per cycle sustained throughput.
// Optional feature macro: ALU_DECODER_ILLEGAL_EN -- when defined, undecodable
// instructions raise the illegal output; otherwise illegal is tied low and
// such instructions decode as a NOP.
module alu_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_WIDTH-1:0]  alu_sel,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  src_a_pc,
  output logic                  src_b_imm,
  output logic                  reg_write,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  illegal
);

  localparam logic [SEL_WIDTH-1:0] SEL_ADD   = SEL_WIDTH'(4'b0000);
  localparam logic [SEL_WIDTH-1:0] SEL_SUB   = SEL_WIDTH'(4'b0001);
  localparam logic [SEL_WIDTH-1:0] SEL_SLL   = SEL_WIDTH'(4'b0010);
  localparam logic [SEL_WIDTH-1:0] SEL_SLT   = SEL_WIDTH'(4'b0011);
  localparam logic [SEL_WIDTH-1:0] SEL_SLTU  = SEL_WIDTH'(4'b0100);
  localparam logic [SEL_WIDTH-1:0] SEL_XOR   = SEL_WIDTH'(4'b0101);
  localparam logic [SEL_WIDTH-1:0] SEL_SRL   = SEL_WIDTH'(4'b0110);
  localparam logic [SEL_WIDTH-1:0] SEL_SRA   = SEL_WIDTH'(4'b0111);
  localparam logic [SEL_WIDTH-1:0] SEL_OR    = SEL_WIDTH'(4'b1000);
  localparam logic [SEL_WIDTH-1:0] SEL_AND   = SEL_WIDTH'(4'b1001);
  localparam logic [SEL_WIDTH-1:0] SEL_B_OUT = SEL_WIDTH'(4'b1111);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Sign-extend a 12-bit immediate field to the data width.
  function automatic logic [DATA_WIDTH-1:0] sext12(input logic signed [11:0] v);
    return DATA_WIDTH'(v);
  endfunction

  // Sign-extend a 32-bit U-type value to the data width.
  function automatic logic [DATA_WIDTH-1:0] sext32(input logic signed [31:0] v);
    return DATA_WIDTH'(v);
  endfunction

  // Map funct3 to an ALU op; alt selects SUB/SRA on the two shared slots.
  function automatic logic [SEL_WIDTH-1:0] sel_from_f3(input logic [2:0] f3, input logic alt);
    logic [SEL_WIDTH-1:0] s;
    case (f3)
      3'b000:  s = alt ? SEL_SUB : SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = alt ? SEL_SRA : SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic                  w_accept;
  logic [SEL_WIDTH-1:0]  w_sel_p0;
  logic [DATA_WIDTH-1:0] w_imm_p0;
  logic                  w_apc_p0;
  logic                  w_bimm_p0;
  logic                  w_rw_p0;
  logic                  w_ill_p0;
  logic                  w_ill_out_p0;

  logic                  r_vld_p1;
  logic [SEL_WIDTH-1:0]  r_sel_p1;
  logic [DATA_WIDTH-1:0] r_imm_p1;
  logic                  r_apc_p1;
  logic                  r_bimm_p1;
  logic                  r_rw_p1;
  logic [4:0]            r_rs1_p1;
  logic [4:0]            r_rs2_p1;
  logic [4:0]            r_rd_p1;
  logic                  r_ill_p1;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];

  // The stage can take a new word whenever it is empty or being drained.
  assign in_ready = !r_vld_p1 || out_ready;
  assign w_accept = in_valid && in_ready;

  // Decode the presented instruction word into the control bundle.
  always_comb begin
    w_sel_p0  = SEL_ADD;
    w_imm_p0  = '0;
    w_apc_p0  = 1'b0;
    w_bimm_p0 = 1'b0;
    w_rw_p0   = 1'b0;
    w_ill_p0  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_rw_p0 = 1'b1;
        if (w_f7 == F7_BASE)
          w_sel_p0 = sel_from_f3(w_f3, 1'b0);
        else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))
          w_sel_p0 = sel_from_f3(w_f3, 1'b1);
        else
          w_ill_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        w_rw_p0   = 1'b1;
        w_bimm_p0 = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shift-immediates carry a shamt, not a signed immediate.
          w_imm_p0 = DATA_WIDTH'(instr[24:20]);
          if (w_f7 == F7_BASE)
            w_sel_p0 = sel_from_f3(w_f3, 1'b0);
          else if (w_f7 == F7_ALT && w_f3 == 3'b101)
            w_sel_p0 = SEL_SRA;
          else
            w_ill_p0 = 1'b1;
        end else begin
          w_imm_p0 = sext12(instr[31:20]);
          w_sel_p0 = sel_from_f3(w_f3, 1'b0);
        end
      end
      OPC_LUI: begin
        w_sel_p0  = SEL_B_OUT;
        w_imm_p0  = sext32({instr[31:12], 12'b0});
        w_bimm_p0 = 1'b1;
        w_rw_p0   = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm_p0  = sext32({instr[31:12], 12'b0});
        w_apc_p0  = 1'b1;
        w_bimm_p0 = 1'b1;
        w_rw_p0   = 1'b1;
      end
      OPC_LOAD: begin
        w_imm_p0  = sext12(instr[31:20]);
        w_bimm_p0 = 1'b1;
        w_rw_p0   = 1'b1;
      end
      OPC_STORE: begin
        w_imm_p0  = sext12({instr[31:25], instr[11:7]});
        w_bimm_p0 = 1'b1;
      end
      default: w_ill_p0 = 1'b1;
    endcase
    // Undecodable words collapse to a harmless ADD with no writeback.
    if (w_ill_p0) begin
      w_sel_p0  = SEL_ADD;
      w_imm_p0  = '0;
      w_apc_p0  = 1'b0;
      w_bimm_p0 = 1'b0;
      w_rw_p0   = 1'b0;
    end
  end

`ifdef ALU_DECODER_ILLEGAL_EN
  assign w_ill_out_p0 = w_ill_p0;
`else
  assign w_ill_out_p0 = 1'b0;
`endif

  // ---- stage p0 -> p1: capture decoded bundle on accept ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_sel_p1  <= '0;
      r_imm_p1  <= '0;
      r_apc_p1  <= 1'b0;
      r_bimm_p1 <= 1'b0;
      r_rw_p1   <= 1'b0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_rd_p1   <= '0;
      r_ill_p1  <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_sel_p1  <= w_sel_p0;
      r_imm_p1  <= w_imm_p0;
      r_apc_p1  <= w_apc_p0;
      r_bimm_p1 <= w_bimm_p0;
      r_rw_p1   <= w_rw_p0;
      r_rs1_p1  <= instr[19:15];
      r_rs2_p1  <= instr[24:20];
      r_rd_p1   <= instr[11:7];
      r_ill_p1  <= w_ill_out_p0;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign alu_sel   = r_sel_p1;
  assign imm       = r_imm_p1;
  assign src_a_pc  = r_apc_p1;
  assign src_b_imm = r_bimm_p1;
  assign reg_write = r_rw_p1;
  assign rs1       = r_rs1_p1;
  assign rs2       = r_rs2_p1;
  assign rd        = r_rd_p1;
  assign illegal   = r_ill_p1;

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed and randomized bench for alu_decoder. The
// reference model decodes by instruction mnemonic and tracks the one-entry
// handshake; expectations for illegal follow ALU_DECODER_ILLEGAL_EN.
module tb_alu_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] imm;
  logic        src_a_pc;
  logic        src_b_imm;
  logic        reg_write;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  alu_decoder #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .imm(imm), .src_a_pc(src_a_pc), .src_b_imm(src_b_imm),
    .reg_write(reg_write), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef ALU_DECODER_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string r_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "ADD";
      3'd1: return "SLL";
      3'd2: return "SLT";
      3'd3: return "SLTU";
      3'd4: return "XOR";
      3'd5: return "SRL";
      3'd6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic string mnem(input logic [31:0] w);
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00) return r_name(f3);
        if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
        if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
        return "ILL";
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? "SLLI" : "ILL";
        if (f3 == 3'd5) return (f7 == 7'h00) ? "SRLI" : (f7 == 7'h20) ? "SRAI" : "ILL";
        return {r_name(f3), "I"};
      end
      7'h37: return "LUI";
      7'h17: return "AUIPC";
      7'h03: return "LOAD";
      7'h23: return "STORE";
      default: return "ILL";
    endcase
  endfunction

  function automatic logic [3:0] sel_of(input string m);
    case (m)
      "SUB":                  return 4'd1;
      "SLL", "SLLI":          return 4'd2;
      "SLT", "SLTI":          return 4'd3;
      "SLTU", "SLTUI":        return 4'd4;
      "XOR", "XORI":          return 4'd5;
      "SRL", "SRLI":          return 4'd6;
      "SRA", "SRAI":          return 4'd7;
      "OR", "ORI":            return 4'd8;
      "AND", "ANDI":          return 4'd9;
      "LUI":                  return 4'd15;
      default:                return 4'd0;
    endcase
  endfunction

  // Packs {illegal, a_pc, b_imm, reg_write, sel, imm, rs1, rs2, rd}.
  function automatic logic [63:0] ref_bundle(input logic [31:0] w);
    string m = mnem(w);
    int    iv = 0;
    logic  ill = (m == "ILL");
    logic  apc = (m == "AUIPC");
    logic  bimm = !ill && (w[6:0] != 7'h33);
    logic  rw = !ill && (m != "STORE");
    if (m == "SLLI" || m == "SRLI" || m == "SRAI") iv = int'(w[24:20]);
    else if (m == "LUI" || m == "AUIPC")          iv = int'(w & 32'hFFFF_F000);
    else if (m == "STORE")                         iv = int'($signed(w[31:25])) * 32 + int'(w[11:7]);
    else if (!ill && w[6:0] != 7'h33)              iv = int'($signed(w[31:20]));
    return {9'd0, ill & ILL_EN, apc, bimm, rw, sel_of(m), iv[31:0], w[19:15], w[24:20], w[11:7]};
  endfunction

  function automatic logic [63:0] dut_bundle();
    return {9'd0, illegal, src_a_pc, src_b_imm, reg_write, alu_sel, imm, rs1, rs2, rd};
  endfunction

  // Handshake model state.
  logic        m_vld;
  logic [63:0] m_bnd;

  // Advance one clock; update the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0;
      m_bnd = '0;
    end else if (in_valid && (!m_vld || out_ready)) begin
      m_vld = 1'b1;
      m_bnd = ref_bundle(instr);
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".vld"}, 64'(out_valid), 64'(m_vld));
    check({tag, ".rdy"}, 64'(in_ready), 64'(!m_vld || out_ready));
    if (m_vld) check({tag, ".bundle"}, dut_bundle(), m_bnd);
  endtask

  // Present one word with a free downstream and check it one cycle later.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1; instr = w; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("send.vld", 64'(out_valid), 64'd1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h00};
    int k = $urandom_range(0, 6);
    w[6:0] = (k == 6) ? 7'($urandom) : ops[k];
    if (k <= 1) begin
      int f = $urandom_range(0, 9);
      w[31:25] = (f < 5) ? 7'h00 : (f < 9) ? 7'h20 : 7'($urandom);
    end
    return w;
  endfunction

  logic [63:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    m_vld = 1'b0; m_bnd = '0;
    tick(); tick();
    rst = 1'b0; #1;
    check("reset.vld", 64'(out_valid), 64'd0);
    check("reset.bundle", dut_bundle(), 64'd0);
    check("reset.rdy", 64'(in_ready), 64'd1);

    // add x3,x1,x2
    send(32'h002081B3);
    check("add.sel", 64'(alu_sel), 64'h0);
    check("add.rs1", 64'(rs1), 64'd1);
    check("add.rs2", 64'(rs2), 64'd2);
    check("add.rd", 64'(rd), 64'd3);
    check("add.bimm", 64'(src_b_imm), 64'd0);
    check("add.rw", 64'(reg_write), 64'd1);
    // sub, srai
    send(32'h402081B3);
    check("sub.sel", 64'(alu_sel), 64'h1);
    send(32'h40335293);
    check("srai.sel", 64'(alu_sel), 64'h7);
    check("srai.imm", 64'(imm), 64'h3);
    check("srai.bimm", 64'(src_b_imm), 64'd1);
    // lui, addi -1
    send(32'h123450B7);
    check("lui.sel", 64'(alu_sel), 64'hF);
    check("lui.imm", 64'(imm), 64'h12345000);
    send(32'hFFF00093);
    check("addi.imm", 64'(imm), 64'hFFFFFFFF);
    // all-ones word is undecodable
    send(32'hFFFFFFFF);
    check("ill.flag", 64'(illegal), 64'(ILL_EN));
    check("ill.rw", 64'(reg_write), 64'd0);
    check("ill.sel", 64'(alu_sel), 64'h0);

    // Back-pressure: hold three cycles, then stream one per cycle.
    out_ready = 1'b1; tick();
    in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b0;
    tick();
    held = dut_bundle();
    check("stall.first", held, ref_bundle(32'h002081B3));
    instr = 32'h402081B3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.rdy", 64'(in_ready), 64'd0);
      tick();
      check("stall.vld", 64'(out_valid), 64'd1);
      check("stall.hold", dut_bundle(), held);
    end
    out_ready = 1'b1;
    begin
      logic [31:0] seq [4] = '{32'h402081B3, 32'h40335293, 32'h123450B7, 32'hFFF00093};
      for (int i = 0; i < 4; i++) begin
        instr = seq[i];
        #1;
        check("stream.rdy", 64'(in_ready), 64'd1);
        tick();
        check("stream.vld", 64'(out_valid), 64'd1);
        check("stream.bundle", dut_bundle(), ref_bundle(seq[i]));
      end
    end
    in_valid = 1'b0; tick();
    check("drain.vld", 64'(out_valid), 64'd0);

    // Reset while holding a bundle; the word offered with reset is dropped.
    in_valid = 1'b1; instr = 32'h123450B7; out_ready = 1'b0;
    tick();
    check("prerst.vld", 64'(out_valid), 64'd1);
    rst = 1'b1; instr = 32'h002081B3;
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    check("rst.vld", 64'(out_valid), 64'd0);
    check("rst.bundle", dut_bundle(), 64'd0);
    check("rst.rdy", 64'(in_ready), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr     = rnd_instr();
      tick();
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
